// File: rtl/demux_1_8_collect.sv
// rtl/demux_1_8_collect.sv - registered 1:8 bit demultiplexer collecting bits into a valid/ready word
module demux_1_8_collect #(
   parameter bit   LSB_FIRST = 1'b1,
   parameter logic FILL_VAL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] sel,
   input  logic       mode,
   input  logic       flush,
   output logic [7:0] out_word,
   output logic [7:0] out_mask,
   output logic       out_valid,
   input  logic       out_ready
);

   localparam logic [2:0] START_LANE = LSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [2:0] LAST_LANE  = LSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [7:0] FILL_WORD  = {8{FILL_VAL}};

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_HOLD    = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_word;
   logic [7:0] r_mask;
   logic [2:0] r_ptr;
   logic       r_word_mode;
   logic       r_valid;

   logic       w_accept;
   logic       w_eff_mode;
   logic [2:0] w_lane;
   logic [7:0] w_lane_onehot;
   logic [7:0] w_word_upd;
   logic [7:0] w_mask_upd;
   logic [7:0] w_mask_next;
   logic       w_word_done;
   logic       w_commit;

   // Lane routing: mode is only sampled on the first bit of a word, later bits reuse the latched mode
   always_comb begin
      w_accept      = in_valid & (r_state == S_COLLECT) & ~rst;
      w_eff_mode    = (r_mask == 8'h00) ? mode : r_word_mode;
      w_lane        = w_eff_mode ? r_ptr : sel;
      w_lane_onehot = 8'b0000_0001 << w_lane;
      w_word_upd    = in_bit ? (r_word | w_lane_onehot) : (r_word & ~w_lane_onehot);
      w_mask_upd    = r_mask | w_lane_onehot;
      w_mask_next   = w_accept ? w_mask_upd : r_mask;
      w_word_done   = w_eff_mode ? (w_lane == LAST_LANE) : (w_mask_upd == 8'hFF);
      w_commit      = (r_state == S_COLLECT) &
                      ((w_accept & w_word_done) | (flush & (w_mask_next != 8'h00)));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and in_ready decode; in_ready depends only on state, held low during reset
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      case (r_state)
         S_COLLECT: begin
            in_ready = ~rst;
            if (w_commit) begin
               w_state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               w_state_next = S_COLLECT;
            end
         end
         default: w_state_next = S_COLLECT;
      endcase
   end

   // Word/mask/pointer datapath: fill lanes while collecting, freeze while holding, clear on handoff
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word      <= FILL_WORD;
         r_mask      <= 8'h00;
         r_ptr       <= START_LANE;
         r_word_mode <= 1'b0;
         r_valid     <= 1'b0;
      end else if (r_state == S_HOLD) begin
         if (out_ready) begin
            r_word  <= FILL_WORD;
            r_mask  <= 8'h00;
            r_ptr   <= START_LANE;
            r_valid <= 1'b0;
         end
      end else begin
         if (w_accept) begin
            r_word      <= w_word_upd;
            r_mask      <= w_mask_upd;
            r_word_mode <= w_eff_mode;
            if (w_eff_mode) begin
               r_ptr <= LSB_FIRST ? (r_ptr + 3'd1) : (r_ptr - 3'd1);
            end
         end
         if (w_commit) begin
            r_valid <= 1'b1;
         end
      end
   end

   assign out_word  = r_word;
   assign out_mask  = r_mask;
   assign out_valid = r_valid;

endmodule
